aurora_tx_arb: RTL and testbench
================================

Name: aurora_tx_arb

Overview:
- Frame-granular round-robin arbiter that shares the single Aurora TX AXI-Stream (32-bit, tlast-delimited frames) between NUM_SRC requesters.
- Sits in front of the TX sequence-number stage, on the Aurora user clock.
- Gates new grants on link state (channel_up).
- Flushes the in-flight frame if the link drops, and exposes grant and drop status for the register interface.

Parameters:
- NUM_SRC, 2, number of requesting AXI-Stream sources (2..4).
- IDX_W, 1, width of grant index; must equal clog2(NUM_SRC), minimum 1.
- DROP_W, 16, width of dropped-frame counter.

Ports:
- usr_clk  in  1  Aurora user clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- channel_up  in  1  Aurora channel status; synchronous to usr_clk.
- src_en  in  NUM_SRC  per-source enable mask (from control register).
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tdata  in  NUM_SRC*32  source i occupies bits [32*i+31 : 32*i].
- s_axis_tlast  in  NUM_SRC  per-source end of frame.
- s_axis_tready  out  NUM_SRC  per-source ready.
- m_axis_tvalid  out  1  to TX pipeline.
- m_axis_tdata  out  32  to TX pipeline.
- m_axis_tlast  out  1  to TX pipeline.
- m_axis_tready  in  1  from TX pipeline.
- grant_idx  out  IDX_W  index of the current or last granted source.
- busy  out  1  high in PASS or FLUSH.
- drop_cnt  out  DROP_W  frames flushed due to link loss; saturating.

Behaviour:
- Reset values (asynchronous): state=IDLE, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, grant_idx=NUM_SRC-1 (so source 0 wins first), busy=0, drop_cnt=0.
- States: IDLE, PASS, FLUSH.
- IDLE:
  - All s_axis_tready=0; m_axis_tvalid=0.
  - Eligible source i: s_axis_tvalid[i] & src_en[i].
  - If channel_up=1 and any source is eligible, pick the first eligible index searching from grant_idx+1 (mod NUM_SRC) upward. Register it into grant_idx and go to PASS next cycle.
  - channel_up=0: stay in IDLE, no grant.
- PASS (g = grant_idx):
  - Combinational pass-through, zero added latency:
    - m_axis_tvalid = s_axis_tvalid[g]
    - m_axis_tdata = s_axis_tdata[g]
    - m_axis_tlast = s_axis_tlast[g]
    - s_axis_tready[g] = m_axis_tready
    - all other s_axis_tready = 0.
  - Non-granted data is ignored; when invalid, m_axis_tdata is 0.
  - Grant is locked until the tlast beat handshakes (valid & ready & last), then the next state is IDLE.
  - Consequence: exactly one idle bubble cycle between frames.
  - src_en[g] falling mid-frame has no effect; the frame completes.
- Link loss in PASS:
  - If channel_up=0 in PASS, go to FLUSH on that edge. The beat presented in that cycle is not forwarded: m_axis_tvalid is forced to 0 whenever channel_up=0.
- FLUSH:
  - m_axis_tvalid=0; s_axis_tready[g]=1; beats from g are discarded.
  - When the tlast beat from g is accepted, increment drop_cnt (saturate at all-ones) and go to IDLE.
  - channel_up returning high during FLUSH does not shorten the flush.
- Simultaneous tlast handshake and channel_up fall in PASS: the beat is not forwarded. Treat it as a flushed frame: drop_cnt+1, go to IDLE directly.
- busy = (state != IDLE).
- m_axis_tready low holds the granted source stalled; no timeout.
- Reset mid-frame aborts immediately; the partial frame is not completed on the output.

Optional Feature:
- Macro: AURORA_TX_ARB_STATS_EN.
- Defined:
  - Adds output frame_cnt (NUM_SRC*32 bits).
  - Per-source wrapping counters increment on each forwarded tlast handshake in PASS.
  - Flushed frames are not counted.
  - Asynchronous reset to 0.
  - Adds input stats_clr (1 bit): synchronously zeroes all counters. If stats_clr coincides with an increment, the counter ends at 0.
- Not defined: no frame_cnt or stats_clr ports; no counter logic.

Test Plan:
- Single source:
  - Setup: channel_up=1, src_en=2'b11; source 0 sends 3-beat frame 0xA0,0xA1,0xA2(last); m_axis_tready=1.
  - Required: grant_idx=0 one cycle after valid; output beats identical, back-to-back; busy falls the cycle after last.
- Round robin:
  - Setup: both sources continuously valid, 2-beat frames each.
  - Required: output frame order src0, src1, src0, src1; one bubble cycle between frames; no interleaving within a frame.
- Masking:
  - Setup: src_en=2'b10, both valid.
  - Required: only source 1 is granted; s_axis_tready[0] stays 0.
  - Then clear src_en[1] mid-frame. Required: that frame still completes.
- Link drop:
  - Setup: drop channel_up after beat 2 of a 5-beat frame from source 1.
  - Required: m_axis_tvalid=0 from that cycle; beats 3-5 are accepted (tready=1) and discarded; drop_cnt 0→1; state IDLE.
  - Then, with channel_up low and sources valid: no grant.
- Backpressure and reset:
  - Setup: hold m_axis_tready=0 for 10 cycles mid-frame. Required: data held stable, no beat lost.
  - Then assert reset. Required: all outputs take reset values immediately (asynchronously).
- Stats, with AURORA_TX_ARB_STATS_EN defined:
  - Setup: 4 frames from source 0, 1 flushed frame from source 1.
  - Required: frame_cnt[0]=4, frame_cnt[1]=0.
  - Then pulse stats_clr. Required: all counters 0.

Source files
------------

// File: rtl/aurora_tx_arb.sv
// Frame-granular round-robin arbiter feeding the Aurora TX AXI-Stream; gated by channel_up, flushes on link loss.
// Optional per-source frame counters: define AURORA_TX_ARB_STATS_EN.
module aurora_tx_arb #(
    parameter int NUM_SRC = 2,
    parameter int IDX_W   = 1,
    parameter int DROP_W  = 16
) (
    input  logic                  usr_clk,
    input  logic                  reset,
    input  logic                  channel_up,
    input  logic [NUM_SRC-1:0]    src_en,
    input  logic [NUM_SRC-1:0]    s_axis_tvalid,
    input  logic [NUM_SRC*32-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]    s_axis_tlast,
    output logic [NUM_SRC-1:0]    s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [31:0]           m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  busy,
    output logic [DROP_W-1:0]     drop_cnt
`ifdef AURORA_TX_ARB_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [NUM_SRC*32-1:0] frame_cnt
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_FLUSH} state_t;

    state_t             state;
    logic [NUM_SRC-1:0] eligible;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic               g_valid;
    logic               g_last;
    logic [31:0]        g_data;
    logic               src_hs;
    logic               flush_done;

    // Round-robin search starting one past the last grant, so the previous winner has lowest priority.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        eligible   = s_axis_tvalid & src_en;
        pick_valid = 1'b0;
        pick_idx   = grant_idx;
        cand       = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = IDX_W'((int'(grant_idx) + k) % NUM_SRC);
            if (!pick_valid && eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        g_valid       = s_axis_tvalid[grant_idx];
        g_last        = s_axis_tlast[grant_idx];
        g_data        = s_axis_tdata[32*grant_idx +: 32];
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        case (state)
            ST_PASS: begin
                s_axis_tready[grant_idx] = m_axis_tready;
                m_axis_tvalid            = g_valid & channel_up;
                m_axis_tdata             = m_axis_tvalid ? g_data : 32'd0;
                m_axis_tlast             = g_last;
            end
            ST_FLUSH: s_axis_tready[grant_idx] = 1'b1;
            default: ;
        endcase
    end

    // A source-side handshake on the last beat ends the frame; without the link it counts as dropped.
    assign src_hs     = g_valid & s_axis_tready[grant_idx];
    assign flush_done = src_hs & g_last &
                        ((state == ST_FLUSH) || ((state == ST_PASS) && !channel_up));
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge usr_clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state     <= ST_IDLE;
            grant_idx <= IDX_W'(NUM_SRC - 1);
            drop_cnt  <= '0;
        end else begin
            if (flush_done && (drop_cnt != '1))
                drop_cnt <= drop_cnt + DROP_W'(1);
            case (state)
                ST_IDLE: begin
                    if (channel_up && pick_valid) begin
                        grant_idx <= pick_idx;
                        state     <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (src_hs && g_last)
                        state <= ST_IDLE;
                    else if (!channel_up)
                        state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (flush_done)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AURORA_TX_ARB_STATS_EN
    logic        fwd_done;
    logic [31:0] frame_q [NUM_SRC];

    assign fwd_done = (state == ST_PASS) && channel_up && src_hs && g_last;

    always_ff @(posedge usr_clk or posedge reset) begin
        // NOTE: the counters are individual flops, not RAM, so they can and do take the async reset.
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++)
                frame_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (stats_clr)
                    frame_q[i] <= '0;
                else if (fwd_done && (grant_idx == IDX_W'(i)))
                    frame_q[i] <= frame_q[i] + 32'd1;
            end
        end
    end

    always_comb begin
        frame_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++)
            frame_cnt[32*i +: 32] = frame_q[i];
    end
`endif

endmodule

// File: tb/tb_aurora_tx_arb.sv
// Directed bench for aurora_tx_arb (two sources); stats checks run when AURORA_TX_ARB_STATS_EN is defined.
module tb_aurora_tx_arb;

    logic        usr_clk = 1'b0;
    logic        reset;
    logic        channel_up;
    logic [1:0]  src_en;
    logic [1:0]  s_axis_tvalid;
    logic [63:0] s_axis_tdata;
    logic [1:0]  s_axis_tlast;
    logic [1:0]  s_axis_tready;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [0:0]  grant_idx;
    logic        busy;
    logic [15:0] drop_cnt;
`ifdef AURORA_TX_ARB_STATS_EN
    logic        stats_clr;
    logic [63:0] frame_cnt;
`endif

    aurora_tx_arb #(.NUM_SRC(2), .IDX_W(1), .DROP_W(16)) dut (
        .usr_clk       (usr_clk),
        .reset         (reset),
        .channel_up    (channel_up),
        .src_en        (src_en),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .grant_idx     (grant_idx),
        .busy          (busy),
        .drop_cnt      (drop_cnt)
`ifdef AURORA_TX_ARB_STATS_EN
        ,
        .stats_clr     (stats_clr),
        .frame_cnt     (frame_cnt)
`endif
    );

    always #5 usr_clk = ~usr_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Source beats are {last, data}; the output log records every forwarded beat and its cycle.
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [31:0] log_data[$];
    logic        log_last[$];
    int          log_cyc[$];
    logic        tready0_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        s_axis_tvalid = 2'b00;
        s_axis_tdata  = '0;
        s_axis_tlast  = 2'b00;
        if (q0.size() != 0) begin
            s_axis_tvalid[0]     = 1'b1;
            s_axis_tdata[31:0]   = q0[0][31:0];
            s_axis_tlast[0]      = q0[0][32];
        end
        if (q1.size() != 0) begin
            s_axis_tvalid[1]     = 1'b1;
            s_axis_tdata[63:32]  = q1[0][31:0];
            s_axis_tlast[1]      = q1[0][32];
        end
    endtask

    // Sample handshakes mid-cycle, advance one clock, retire accepted beats and present the next ones.
    task automatic tick();
        logic [1:0] hs;
        @(negedge usr_clk);
        hs = s_axis_tvalid & s_axis_tready;
        tready0_seen = tready0_seen | s_axis_tready[0];
        if (m_axis_tvalid && m_axis_tready) begin
            log_data.push_back(m_axis_tdata);
            log_last.push_back(m_axis_tlast);
            log_cyc.push_back(cyc);
        end
        @(posedge usr_clk);
        cyc++;
        #1;
        if (hs[0]) void'(q0.pop_front());
        if (hs[1]) void'(q1.pop_front());
        drive();
        #1;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_last.delete();
        log_cyc.delete();
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 60 && (q0.size() != 0 || q1.size() != 0); n++)
            tick();
        check({tag, "_drained"}, 64'(q0.size() + q1.size()), 64'd0);
        tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        q0.delete();
        q1.delete();
        drive();
        clear_log();
    endtask

    initial begin
        reset         = 1'b1;
        channel_up    = 1'b1;
        src_en        = 2'b11;
        m_axis_tready = 1'b1;
        tready0_seen  = 1'b0;
`ifdef AURORA_TX_ARB_STATS_EN
        stats_clr     = 1'b0;
`endif
        drive();
        #1;
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_tlast",  64'(m_axis_tlast),  64'd0);
        check("rst_m_tdata",  64'(m_axis_tdata),  64'd0);
        check("rst_grant",    64'(grant_idx),     64'd1);
        check("rst_busy",     64'(busy),          64'd0);
        check("rst_drop",     64'(drop_cnt),      64'd0);
        @(posedge usr_clk);
        #1;
        reset = 1'b0;
        #1;

        // Single source, three back-to-back beats.
        q0.push_back({1'b0, 32'hA0});
        q0.push_back({1'b0, 32'hA1});
        q0.push_back({1'b1, 32'hA2});
        drive();
        #1;
        check("t1_idle_busy", 64'(busy), 64'd0);
        tick();
        check("t1_grant",   64'(grant_idx),     64'd0);
        check("t1_busy",    64'(busy),          64'd1);
        check("t1_tvalid",  64'(m_axis_tvalid), 64'd1);
        check("t1_tdata0",  64'(m_axis_tdata),  64'hA0);
        tick();
        tick();
        tick();
        check("t1_busy_fall", 64'(busy), 64'd0);
        check("t1_nbeats", 64'(log_data.size()), 64'd3);
        check("t1_beat1",  64'(log_data[1]), 64'hA1);
        check("t1_beat2",  64'(log_data[2]), 64'hA2);
        check("t1_last2",  64'(log_last[2]), 64'd1);
        check("t1_last0",  64'(log_last[0]), 64'd0);
        check("t1_b2b",    64'(log_cyc[2] - log_cyc[0]), 64'd2);

        // Round robin with both sources continuously valid.
        pulse_reset();
        q0.push_back({1'b0, 32'hB00}); q0.push_back({1'b1, 32'hB01});
        q0.push_back({1'b0, 32'hB02}); q0.push_back({1'b1, 32'hB03});
        q1.push_back({1'b0, 32'hC10}); q1.push_back({1'b1, 32'hC11});
        q1.push_back({1'b0, 32'hC12}); q1.push_back({1'b1, 32'hC13});
        drive();
        drain("t2");
        check("t2_nbeats", 64'(log_data.size()), 64'd8);
        check("t2_b0", 64'(log_data[0]), 64'hB00);
        check("t2_b1", 64'(log_data[1]), 64'hB01);
        check("t2_b2", 64'(log_data[2]), 64'hC10);
        check("t2_b3", 64'(log_data[3]), 64'hC11);
        check("t2_b4", 64'(log_data[4]), 64'hB02);
        check("t2_b5", 64'(log_data[5]), 64'hB03);
        check("t2_b6", 64'(log_data[6]), 64'hC12);
        check("t2_b7", 64'(log_data[7]), 64'hC13);
        check("t2_inframe_gap", 64'(log_cyc[1] - log_cyc[0]), 64'd1);
        check("t2_bubble",      64'(log_cyc[2] - log_cyc[1]), 64'd2);

        // Masking: source 0 disabled, then source 1 disabled mid-frame.
        clear_log();
        src_en = 2'b10;
        q0.push_back({1'b0, 32'hD0}); q0.push_back({1'b1, 32'hD1});
        q1.push_back({1'b0, 32'hE0}); q1.push_back({1'b0, 32'hE1}); q1.push_back({1'b1, 32'hE2});
        drive();
        tready0_seen = 1'b0;
        tick();
        check("t3_grant", 64'(grant_idx), 64'd1);
        tick();
        src_en = 2'b00;
        tick();
        tick();
        check("t3_nbeats",  64'(log_data.size()), 64'd3);
        check("t3_beat2",   64'(log_data[2]), 64'hE2);
        check("t3_busy",    64'(busy), 64'd0);
        check("t3_tready0", 64'(tready0_seen), 64'd0);
        q0.delete();
        drive();
        src_en = 2'b11;

        // Link drop after beat 2 of a 5-beat frame from source 1.
        clear_log();
        for (int i = 0; i < 5; i++)
            q1.push_back({(i == 4), 32'hF0 + 32'(i)});
        drive();
        tick();
        check("t4_grant", 64'(grant_idx), 64'd1);
        tick();
        tick();
        channel_up = 1'b0;
        #1;
        check("t4_tvalid_drop", 64'(m_axis_tvalid), 64'd0);
        check("t4_tready_drop", 64'(s_axis_tready), 64'b10);
        tick();
        check("t4_flush_busy",   64'(busy), 64'd1);
        check("t4_flush_tready", 64'(s_axis_tready), 64'b10);
        check("t4_flush_tvalid", 64'(m_axis_tvalid), 64'd0);
        tick();
        tick();
        check("t4_drop",   64'(drop_cnt), 64'd1);
        check("t4_idle",   64'(busy), 64'd0);
        check("t4_nbeats", 64'(log_data.size()), 64'd2);
        check("t4_q1_empty", 64'(q1.size()), 64'd0);
        q0.push_back({1'b1, 32'h55});
        q1.push_back({1'b1, 32'h66});
        drive();
        tick(); tick(); tick();
        check("t4_nogrant_busy",  64'(busy), 64'd0);
        check("t4_nogrant_ready", 64'(s_axis_tready), 64'd0);
        check("t4_nogrant_idx",   64'(grant_idx), 64'd1);
        q0.delete();
        q1.delete();
        drive();
        channel_up = 1'b1;

        // Backpressure for 10 cycles, then asynchronous reset mid-frame.
        clear_log();
        q0.push_back({1'b0, 32'h1000}); q0.push_back({1'b0, 32'h1001}); q0.push_back({1'b1, 32'h1002});
        drive();
        tick();
        tick();
        m_axis_tready = 1'b0;
        #1;
        begin
            logic stable;
            stable = 1'b1;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (m_axis_tdata !== 32'h1001 || m_axis_tvalid !== 1'b1 || s_axis_tready !== 2'b00)
                    stable = 1'b0;
            end
            check("t5_stable", 64'(stable), 64'd1);
        end
        check("t5_held_data", 64'(m_axis_tdata), 64'h1001);
        check("t5_nbeats_stall", 64'(log_data.size()), 64'd1);
        m_axis_tready = 1'b1;
        tick();
        check("t5_nbeats", 64'(log_data.size()), 64'd2);
        check("t5_beat1",  64'(log_data[1]), 64'h1001);
        check("t5_pre_rst_data", 64'(m_axis_tdata), 64'h1002);
        reset = 1'b1;
        #1;
        check("t5_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t5_rst_tready", 64'(s_axis_tready), 64'd0);
        check("t5_rst_tdata",  64'(m_axis_tdata),  64'd0);
        check("t5_rst_tlast",  64'(m_axis_tlast),  64'd0);
        check("t5_rst_busy",   64'(busy),          64'd0);
        check("t5_rst_grant",  64'(grant_idx),     64'd1);
        check("t5_rst_drop",   64'(drop_cnt),      64'd0);
        #2;
        reset = 1'b0;
        q0.delete();
        q1.delete();
        drive();
        clear_log();

`ifdef AURORA_TX_ARB_STATS_EN
        // Four forwarded frames from source 0, one flushed frame from source 1.
        pulse_reset();
        for (int f = 0; f < 4; f++) begin
            q0.push_back({1'b0, 32'h2000 + 32'(2*f)});
            q0.push_back({1'b1, 32'h2001 + 32'(2*f)});
        end
        drive();
        drain("t6");
        q1.push_back({1'b0, 32'h30}); q1.push_back({1'b0, 32'h31}); q1.push_back({1'b1, 32'h32});
        drive();
        tick();
        check("t6_grant", 64'(grant_idx), 64'd1);
        channel_up = 1'b0;
        tick(); tick(); tick();
        check("t6_drop",   64'(drop_cnt), 64'd1);
        check("t6_cnt0",   64'(frame_cnt[31:0]),  64'd4);
        check("t6_cnt1",   64'(frame_cnt[63:32]), 64'd0);
        channel_up = 1'b1;
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("t6_clr", 64'(frame_cnt), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
